// File: rtl/keccak_rand_gen.sv
// keccak_rand_gen: fresh-randomness source for the masked Keccak chi stage.
// A bank of L xorshift32 lanes is seeded lane 0..L-1 over a 32-bit
// valid/ready handshake, stepped WARMUP times, then streams one RW-bit
// refresh word per accepted transfer.
//
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   seed_word    32-bit seed for the current lane
//   seed_valid   seed_word valid
//   seed_ready   seed accepted (high only while seeding)
//   reseed       one-cycle request to reload all seeds (highest priority)
//   rand_data    RW refresh bits, lane k in bits [32k+31:32k], truncated
//   rand_valid   rand_data valid (high only while running)
//   rand_ready   consumer accepts rand_data
//   busy         high while seeding or warming up
//   health_fail  (KECCAK_RAND_HEALTH_EN only) sticky repetition alarm
//
// Optional feature macro: KECCAK_RAND_HEALTH_EN.

module keccak_rand_gen #(
    parameter int SECURITY_ORDER = 1,
    parameter int NUM_SBOX       = 5,
    parameter int WARMUP         = 4,
    localparam int RW = NUM_SBOX * 10 *
                        (SECURITY_ORDER * (SECURITY_ORDER + 1) / 2),
    localparam int L  = (RW + 31) / 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   seed_word,
    input  logic          seed_valid,
    output logic          seed_ready,
    input  logic          reseed,
    output logic [RW-1:0] rand_data,
    output logic          rand_valid,
    input  logic          rand_ready,
    output logic          busy
`ifdef KECCAK_RAND_HEALTH_EN
    ,
    output logic          health_fail
`endif
);

    typedef enum logic [1:0] {
        ST_SEED,
        ST_WARMUP,
        ST_RUN
    } state_t;

    localparam int IW = (L > 1) ? $clog2(L) : 1;
    localparam int WW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam logic [IW-1:0] IDX_LAST  = IW'(L - 1);
    localparam logic [WW-1:0] WARM_LAST = WW'((WARMUP > 0) ? WARMUP - 1 : 0);

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q;
    logic [WW-1:0] warm_q;
    logic [31:0]   lane_q [L];
    logic [31:0]   seed_load;
    logic          seed_fire;
    logic          xfer;
    logic          lane_step;
    logic          fail_q;

    function automatic logic [31:0] xs_step(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    // Zero is a fixed point of xorshift, so a zero seed is replaced by a
    // lane-unique nonzero constant.
    always_comb begin
        seed_load = seed_word;
        if (seed_word == '0)
            seed_load = 32'h9E3779B9 ^ 32'(idx_q);
    end

    always_comb begin
        seed_ready = (state_q == ST_SEED);
        busy       = (state_q != ST_RUN);
        rand_valid = (state_q == ST_RUN) && !fail_q;
        seed_fire  = seed_valid && seed_ready;
        xfer       = rand_valid && rand_ready;
        // A transfer coinciding with reseed is not a step.
        lane_step  = !reseed && (xfer || (state_q == ST_WARMUP));
        state_d    = state_q;
        unique case (state_q)
            ST_SEED: begin
                if (seed_fire && (idx_q == IDX_LAST))
                    state_d = (WARMUP > 0) ? ST_WARMUP : ST_RUN;
            end
            ST_WARMUP: begin
                if (warm_q == WARM_LAST)
                    state_d = ST_RUN;
            end
            ST_RUN: state_d = ST_RUN;
            default: state_d = ST_SEED;
        endcase
        if (reseed)
            state_d = ST_SEED;
    end

    always_comb begin
        rand_data = '0;
        for (int b = 0; b < RW; b++)
            rand_data[b] = lane_q[b / 32][b % 32];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_SEED;
            idx_q   <= '0;
            warm_q  <= '0;
            for (int k = 0; k < L; k++)
                lane_q[k] <= '0;
        end else begin
            state_q <= state_d;
            if (reseed) begin
                idx_q  <= '0;
                warm_q <= '0;
            end else begin
                if (state_q == ST_WARMUP)
                    warm_q <= (warm_q == WARM_LAST) ? '0 : warm_q + 1'b1;
                if (seed_fire)
                    idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                for (int k = 0; k < L; k++) begin
                    if (seed_fire && (idx_q == IW'(k)))
                        lane_q[k] <= seed_load;
                    else if (lane_step)
                        lane_q[k] <= xs_step(lane_q[k]);
                end
            end
        end
    end

`ifdef KECCAK_RAND_HEALTH_EN
    logic [RW-1:0] prev_q;
    logic          prev_vld;
    logic [1:0]    rep_q;

    // Counts accepted words equal to the previously accepted one; the
    // third such repeat in a row raises the sticky alarm.
    always_ff @(posedge clk) begin
        if (rst || reseed) begin
            prev_q   <= '0;
            prev_vld <= 1'b0;
            rep_q    <= '0;
            fail_q   <= 1'b0;
        end else if (xfer) begin
            prev_q   <= rand_data;
            prev_vld <= 1'b1;
            if (prev_vld && (rand_data == prev_q)) begin
                if (rep_q == 2'd2)
                    fail_q <= 1'b1;
                else
                    rep_q <= rep_q + 2'd1;
            end else begin
                rep_q <= '0;
            end
        end
    end

    assign health_fail = fail_q;
`else
    assign fail_q = 1'b0;
`endif

endmodule

// File: tb/tb_keccak_rand_gen.sv
// Bench for keccak_rand_gen: two instances (WARMUP=0 and WARMUP=4) share
// stimulus; a seed/step-count model checks both every cycle.

module tb_keccak_rand_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reseed = 1'b0;
    logic        seed_valid = 1'b0;
    logic        rand_ready = 1'b0;
    logic [31:0] seed_word = '0;

    logic        seed_ready [2];
    logic        busy [2];
    logic        rand_valid [2];
    logic [49:0] rand_data [2];
`ifdef KECCAK_RAND_HEALTH_EN
    logic        health_fail [2];
`endif

    int pass_cnt = 0;
    int tot_cnt  = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    keccak_rand_gen #(
        .SECURITY_ORDER(1), .NUM_SBOX(5), .WARMUP(0)
    ) u0 (
        .clk(clk), .rst(rst), .seed_word(seed_word),
        .seed_valid(seed_valid), .seed_ready(seed_ready[0]),
        .reseed(reseed), .rand_data(rand_data[0]),
        .rand_valid(rand_valid[0]), .rand_ready(rand_ready),
        .busy(busy[0])
`ifdef KECCAK_RAND_HEALTH_EN
        , .health_fail(health_fail[0])
`endif
    );

    keccak_rand_gen #(
        .SECURITY_ORDER(1), .NUM_SBOX(5), .WARMUP(4)
    ) u4 (
        .clk(clk), .rst(rst), .seed_word(seed_word),
        .seed_valid(seed_valid), .seed_ready(seed_ready[1]),
        .reseed(reseed), .rand_data(rand_data[1]),
        .rand_valid(rand_valid[1]), .rand_ready(rand_ready),
        .busy(busy[1])
`ifdef KECCAK_RAND_HEALTH_EN
        , .health_fail(health_fail[1])
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    function automatic logic [31:0] xs(input logic [31:0] x);
        x = x ^ (x << 13);
        x = x ^ (x >> 17);
        x = x ^ (x << 5);
        return x;
    endfunction

    function automatic logic [31:0] xs_n(input logic [31:0] x, input int n);
        for (int s = 0; s < n; s++) x = xs(x);
        return x;
    endfunction

    function automatic int wu(input int i);
        return (i == 0) ? 0 : 4;
    endfunction

    // Model: which seeds were loaded, when the last one landed, and how
    // many words have been delivered since.
    bit          m_seeding [2] = '{1'b1, 1'b1};
    int          m_idx [2]     = '{0, 0};
    logic [31:0] m_seed [2][2];
    int          m_last [2]    = '{0, 0};
    int          m_n [2]       = '{0, 0};

    function automatic logic [49:0] exp_word(input int i);
        logic [63:0] w;
        w = '0;
        for (int k = 0; k < 2; k++)
            w[32*k +: 32] = xs_n(m_seed[i][k], wu(i) + m_n[i]);
        return w[49:0];
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            automatic bit ev;
            ev = !m_seeding[i] && (cyc >= m_last[i] + 1 + wu(i));
            chk($sformatf("u%0d seed_ready", wu(i)), seed_ready[i], m_seeding[i]);
            chk($sformatf("u%0d busy", wu(i)), busy[i], !ev);
            chk($sformatf("u%0d rand_valid", wu(i)), rand_valid[i], ev);
            if (ev)
                chk($sformatf("u%0d rand_data", wu(i)), rand_data[i], exp_word(i));
`ifdef KECCAK_RAND_HEALTH_EN
            chk($sformatf("u%0d health_fail", wu(i)), health_fail[i], 0);
`endif
            if (rst || reseed) begin
                m_seeding[i] = 1'b1;
                m_idx[i]     = 0;
            end else if (m_seeding[i]) begin
                if (seed_valid) begin
                    m_seed[i][m_idx[i]] = (seed_word == 0) ?
                        (32'h9E3779B9 ^ m_idx[i]) : seed_word;
                    m_idx[i]++;
                    if (m_idx[i] == 2) begin
                        m_seeding[i] = 1'b0;
                        m_last[i]    = cyc;
                        m_n[i]       = 0;
                    end
                end
            end else if (ev && rand_ready) begin
                m_n[i]++;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_seed(input logic [31:0] w);
        tick;
        seed_valid = 1'b1;
        seed_word  = w;
        tick;
        seed_valid = 1'b0;
    endtask

    initial begin
        logic [49:0] save;
        logic [31:0] l0;
        int lat;

        repeat (2) tick;
        rst = 1'b0;
        @(negedge clk);
        chk("reset seed_ready", seed_ready[0], 1);
        chk("reset busy", busy[0], 1);
        chk("reset rand_valid", rand_valid[0], 0);

        // Seeds 1,1: word 0 and word 1 pinned to literals.
        send_seed(32'd1);
        send_seed(32'd1);
        @(negedge clk);
        chk("word0 literal", rand_data[0], {18'd1, 32'd1});
        chk("seed_ready drop", seed_ready[0], 0);
        lat = 1;
        while (!rand_valid[1] && lat < 20) begin
            chk("warmup busy", busy[1], 1);
            tick;
            @(negedge clk);
            lat++;
        end
        chk("warmup latency", lat, 5);
        chk("warmup first word", rand_data[1][31:0], xs_n(32'd1, 4));
        tick;
        rand_ready = 1'b1;
        tick;
        rand_ready = 1'b0;
        @(negedge clk);
        chk("word1 literal", rand_data[0], {18'h02021, 32'h00042021});

        // Backpressure then three accepted transfers.
        tick;
        @(negedge clk);
        save = rand_data[0];
        repeat (5) begin
            tick;
            @(negedge clk);
            chk("hold data", rand_data[0], save);
            chk("hold valid", rand_valid[0], 1);
        end
        tick;
        rand_ready = 1'b1;
        repeat (3) tick;
        rand_ready = 1'b0;
        @(negedge clk);
        l0 = xs_n(save[31:0], 3);
        chk("three steps lane0", rand_data[0][31:0], l0);
        chk("three steps lane1", rand_data[0][49:32], l0[17:0]);

        // Reseed together with a handshake.
        tick;
        rand_ready = 1'b1;
        reseed = 1'b1;
        tick;
        reseed = 1'b0;
        rand_ready = 1'b0;
        @(negedge clk);
        chk("reseed valid", rand_valid[0], 0);
        chk("reseed seed_ready", seed_ready[0], 1);
        send_seed(32'd1);
        send_seed(32'd2);
        @(negedge clk);
        chk("reseed restart", rand_data[0], {18'd2, 32'd1});

        // Reseed during WARMUP of u4, then zero seeds.
        tick;
        reseed = 1'b1;
        tick;
        reseed = 1'b0;
        send_seed(32'd0);
        send_seed(32'd0);
        @(negedge clk);
        chk("zero seed lane0", rand_data[0][31:0], 32'h9E3779B9);
        chk("zero seed word", rand_data[0], {18'h379B8, 32'h9E3779B9});

        // Reset after one of two seeds.
        tick;
        reseed = 1'b1;
        tick;
        reseed = 1'b0;
        send_seed(32'd5);
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        @(negedge clk);
        chk("rst mid seed_ready", seed_ready[0], 1);
        chk("rst mid valid", rand_valid[0], 0);
        send_seed(32'd7);
        @(negedge clk);
        chk("partial no valid", rand_valid[0], 0);
        chk("partial seed_ready", seed_ready[0], 1);
        send_seed(32'd9);
        @(negedge clk);
        chk("reload word", rand_data[0], {18'd9, 32'd7});

        // Random backpressure, seed_valid noise in RUN.
        repeat (40) begin
            tick;
            rand_ready = 1'($urandom_range(0, 1));
            seed_valid = 1'($urandom_range(0, 1));
            seed_word  = $urandom;
        end
        tick;
        rand_ready = 1'b0;
        seed_valid = 1'b0;
        repeat (3) tick;

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/keccak_rand_gen.md
Name: keccak_rand_gen

Overview:
- Fresh-randomness source that feeds the `rand_data` bus of the masked Keccak chi stage (HPC3-gadget S-box row).
- Bank of L independent xorshift32 lanes. Seeded over a 32-bit handshake, warmed up, then streams one refresh word per accepted transfer.
- Sits between the SoC seed/TRNG interface and the masked keccak-f round datapath. The round datapath is the consumer and stalls on `rand_valid`.

Parameters:
- security_order, 1, masking order d; shares = d+1.
- NUM_SBOX, 5, S-box instances fed per word (one plane row).
- WARMUP, 4, lane steps executed after seeding before the first output; 0 is legal.
- Derived: RW = NUM_SBOX*10*(d*(d+1)/2), output width (50 at defaults).
- Derived: L = ceil(RW/32), lane count.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- seed_word  in  32  seed for the current lane, loaded in order lane 0 .. L-1.
- seed_valid  in  1  seed_word valid.
- seed_ready  out  1  accepts seed_word; high only in SEED.
- reseed  in  1  single-cycle request to reload all seeds.
- rand_data  out  RW  refresh bits; bits [32k+31:32k] = lane k state, truncated to RW.
- rand_valid  out  1  rand_data valid; high only in RUN.
- rand_ready  in  1  consumer accepts rand_data.
- busy  out  1  high in SEED and WARMUP.

Behaviour:
- Reset values:
  - state = SEED, lane index = 0, warm counter = 0.
  - All lane registers = 0.
  - rand_valid = 0, seed_ready = 1, busy = 1.
- FSM states: SEED, WARMUP, RUN.
- SEED:
  - seed_ready = 1.
  - On seed_valid & seed_ready, lane[idx] <= seed_word, idx++.
  - A zero seed_word is stored as 32'h9E3779B9 ^ idx, because xorshift has a fixed point at 0.
  - After the lane L-1 transfer: go to WARMUP if WARMUP > 0, else to RUN.
- WARMUP:
  - All lanes step every cycle; counter counts 0 .. WARMUP-1.
  - After WARMUP steps, go to RUN.
  - rand_valid = 0.
- RUN:
  - rand_valid = 1 and rand_data = current lane registers.
  - On rand_valid & rand_ready, all lanes step in the same cycle; the next word is visible the following cycle.
  - With rand_ready held high: one new word per cycle, zero bubbles.
  - With rand_ready low: rand_data is held stable.
- Lane step (bit-exact, applied sequentially):
  1. x ^= x<<13
  2. x ^= x>>17
  3. x ^= x<<5
  - All operations are 32-bit; shifted-out bits are dropped.
- reseed:
  - In any state it takes priority over all other actions in that cycle.
  - Next state = SEED, idx = 0, rand_valid = 0 from the next cycle.
  - Lane registers keep their values until overwritten.
  - A handshake in the same cycle as reseed is not counted as a step; the consumer must treat it as not delivered.
- seed_valid outside SEED is ignored.
- rst mid-operation returns to reset values on the next edge, regardless of handshakes.
- Latency:
  - Last seed accepted at cycle t → rand_valid at t+1+WARMUP.
  - Handshake at cycle t → new word at t+1.
- Never emits a word computed from a partial seed set.

Optional Feature:
- Macro: KECCAK_RAND_HEALTH_EN.
- Defined:
  - Adds output `health_fail` (1 bit, reset 0) and a repetition counter.
  - In RUN, if an accepted rand_data equals the previously accepted word for 3 consecutive transfers, health_fail <= 1.
  - health_fail is sticky until rst or reseed; while it is set, rand_valid is forced 0.
  - The counter clears on reseed and on rst.
- Not defined: no port, no counter; behaviour is otherwise identical.

Test Plan:
- Seed hold, WARMUP=0, d=1, L=2, seeds 1 and 1, rand_ready=1 → word 0 lane 0 = 0x00000001, word 1 lane 0 = 0x00042021 (270369). Lane 1 is identical; rand_data is 50 bits.
- Zero seed, WARMUP=0, seed lane 0 with 0 → first lane 0 output = 0x9E3779B9. Also checks seed_ready drops after the L-th transfer.
- Backpressure: in RUN, rand_ready=0 for 5 cycles → rand_data and rand_valid stable. Then rand_ready=1 for 3 cycles → exactly 3 distinct steps, matching the reference model.
- Warmup latency, WARMUP=4 → rand_valid rises exactly 5 cycles after the last seed handshake. First word = seed stepped 4 times; busy=1 throughout.
- Reseed: reseed pulsed together with a handshake in RUN → rand_valid=0 next cycle, seed_ready=1, idx=0. A new seed of 1 restarts the sequence at 0x00000001.
- Reset mid-SEED: rst asserted after 1 of 2 seeds → seed_ready=1, idx=0, rand_valid=0. A full reload is required; with HEALTH_EN, health_fail=0.
